// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - data-first arbiter sharing one fixed-latency memory between fetch and data stages
module mem_port_arbiter #(
  parameter int AddrWidth  = 32,
  parameter int DataWidth  = 32,
  parameter int MemLatency = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ifReq,
  input  logic [AddrWidth-1:0] ifAddr,
  output logic [DataWidth-1:0] ifData,
  output logic                 ifValid,
  input  logic                 dmReq,
  input  logic                 dmWe,
  input  logic [AddrWidth-1:0] dmAddr,
  input  logic [DataWidth-1:0] dmWdata,
  output logic [DataWidth-1:0] dmRdata,
  output logic                 dmValid,
  output logic                 memEn,
  output logic                 memWe,
  output logic [AddrWidth-1:0] memAddr,
  output logic [DataWidth-1:0] memWdata,
  input  logic [DataWidth-1:0] memRdata,
  output logic                 PCLocker,
  output logic                 IF_IDLocker,
  output logic                 DECLocker
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CntInit = 4'(MemLatency - 1);

  state_t                 state, state_next;
  logic                   grant;      // 0 = fetch owns the memory, 1 = data stage
  logic [3:0]             cnt;
  logic                   issue;
  logic                   lock;
  logic                   we_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   wdata_q;

  // Next state, issue decision and locker value; reset suppresses any issue
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    lock       = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (ifReq || dmReq)) begin
          issue      = 1'b1;
          state_next = WAIT;
        end
        if (!ifReq && !dmReq) lock = 1'b1;
      end
      WAIT: begin
        if (cnt == 4'd0) state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
        if (grant ? !ifReq : !dmReq) lock = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory request bus: live values in the issue cycle, held values afterwards
  assign memEn       = issue;
  assign memWe       = issue ? (dmReq & dmWe) : we_q;
  assign memAddr     = issue ? (dmReq ? dmAddr : ifAddr) : addr_q;
  assign memWdata    = (issue && dmReq) ? dmWdata : wdata_q;
  assign PCLocker    = lock;
  assign IF_IDLocker = lock;
  assign DECLocker   = lock;

  // State, latency countdown, issued-request hold and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= 1'b0;
      cnt     <= 4'd0;
      ifValid <= 1'b0;
      dmValid <= 1'b0;
      ifData  <= '0;
      dmRdata <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_next;
      ifValid <= 1'b0;
      dmValid <= 1'b0;
      if (issue) begin
        grant   <= dmReq;
        cnt     <= CntInit;
        we_q    <= memWe;
        addr_q  <= memAddr;
        wdata_q <= memWdata;
      end
      if (state == WAIT) begin
        if (cnt == 4'd0) begin
          if (grant) begin
            dmValid <= 1'b1;
            // a store still waits out the latency but leaves load data untouched
            if (!we_q) dmRdata <= memRdata;
          end else begin
            ifValid <= 1'b1;
            ifData  <= memRdata;
          end
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a cycle-budget reference model
module tb_mem_port_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // instance with default latency
  logic        rst, ifReq, ifValid, dmReq, dmWe, dmValid, memEn, memWe;
  logic        PCLocker, IF_IDLocker, DECLocker;
  logic [31:0] ifAddr, ifData, dmAddr, dmWdata, dmRdata, memAddr, memWdata, memRdata;

  // instance with latency 1
  logic        rst_1, ifReq_1, ifValid_1, dmReq_1, dmWe_1, dmValid_1, memEn_1, memWe_1;
  logic        PCLocker_1, IF_IDLocker_1, DECLocker_1;
  logic [31:0] ifAddr_1, ifData_1, dmAddr_1, dmWdata_1, dmRdata_1, memAddr_1, memWdata_1, memRdata_1;

  mem_port_arbiter #(.AddrWidth(32), .DataWidth(32), .MemLatency(L)) u_dut (
    .clk(clk), .rst(rst),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData), .ifValid(ifValid),
    .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr), .dmWdata(dmWdata),
    .dmRdata(dmRdata), .dmValid(dmValid),
    .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memRdata(memRdata),
    .PCLocker(PCLocker), .IF_IDLocker(IF_IDLocker), .DECLocker(DECLocker)
  );

  mem_port_arbiter #(.AddrWidth(32), .DataWidth(32), .MemLatency(1)) u_dut_1 (
    .clk(clk), .rst(rst_1),
    .ifReq(ifReq_1), .ifAddr(ifAddr_1), .ifData(ifData_1), .ifValid(ifValid_1),
    .dmReq(dmReq_1), .dmWe(dmWe_1), .dmAddr(dmAddr_1), .dmWdata(dmWdata_1),
    .dmRdata(dmRdata_1), .dmValid(dmValid_1),
    .memEn(memEn_1), .memWe(memWe_1), .memAddr(memAddr_1), .memWdata(memWdata_1), .memRdata(memRdata_1),
    .PCLocker(PCLocker_1), .IF_IDLocker(IF_IDLocker_1), .DECLocker(DECLocker_1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // behavioural memory: written contents, otherwise an address hash
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  typedef struct { int at; logic [31:0] data; } ret_t;
  ret_t ret_q[$];

  // requesters
  bit          if_pend, dm_pend, dm_we_r, obs_ifv, obs_dmv, rst_now;
  logic [31:0] if_addr, dm_addr, dm_wdata;

  // reference model: cycle at which the port is next free, and the pending response
  int          free_at = 0;
  int          vcyc = -1;
  bit          vown, vwe, idle, own, ewe, exp_lock, issue_exp;
  logic [31:0] vdata, exp_if = '0, exp_dm = '0, last_addr = '0, ea;

  initial begin
    rst = 1'b1; ifReq = 1'b1; ifAddr = 32'h100; dmReq = 1'b0; dmWe = 1'b0;
    dmAddr = '0; dmWdata = '0; memRdata = '0;
    rst_1 = 1'b1; ifReq_1 = 1'b0; ifAddr_1 = '0; dmReq_1 = 1'b0; dmWe_1 = 1'b0;
    dmAddr_1 = '0; dmWdata_1 = '0; memRdata_1 = '0;
    if_pend = 1'b1; if_addr = 32'h100; dm_pend = 1'b0; dm_we_r = 1'b0;
    dm_addr = '0; dm_wdata = '0; obs_ifv = 1'b0; obs_dmv = 1'b0;
    @(posedge clk); #1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (obs_ifv) if_pend = 1'b0;
      if (obs_dmv) dm_pend = 1'b0;
      if (cyc >= 2) begin
        if (!if_pend && $urandom_range(0, 2) == 0) begin
          if_pend = 1'b1;
          if_addr = 32'($urandom_range(0, 15)) << 2;
        end
        if (!dm_pend && $urandom_range(0, 3) == 0) begin
          dm_pend  = 1'b1;
          dm_we_r  = 1'($urandom_range(0, 1));
          dm_addr  = 32'($urandom_range(0, 15)) << 2;
          dm_wdata = $urandom;
        end
      end
      rst_now = (cyc < 2) || ($urandom_range(0, 79) == 0);
      rst = rst_now; ifReq = if_pend; ifAddr = if_addr;
      dmReq = dm_pend; dmWe = dm_we_r; dmAddr = dm_addr; dmWdata = dm_wdata;
      if (ret_q.size() > 0 && ret_q[0].at == cyc) memRdata = ret_q.pop_front().data;
      else memRdata = $urandom;

      @(negedge clk);
      idle      = (cyc >= free_at);
      exp_lock  = (idle && !if_pend && !dm_pend) ||
                  (cyc == vcyc && (vown ? !if_pend : !dm_pend));
      issue_exp = !rst_now && idle && (if_pend || dm_pend);
      check_eq("memEn", memEn, issue_exp);
      if (issue_exp) begin
        own = dm_pend;
        ea  = own ? dm_addr : if_addr;
        ewe = own && dm_we_r;
        check_eq("memAddr", memAddr, ea);
        check_eq("memWe", memWe, ewe);
        if (ewe) check_eq("memWdata", memWdata, dm_wdata);
        vcyc = cyc + L + 1; free_at = cyc + L + 2;
        vown = own; vwe = ewe; vdata = mem_read(ea);
        last_addr = ea;
      end else begin
        check_eq("memAddr_hold", memAddr, last_addr);
      end
      if (memEn === 1'b1) begin
        if (memWe) mem[memAddr] = memWdata;
        else ret_q.push_back('{at: cyc + L, data: mem_read(memAddr)});
      end
      if (cyc == vcyc) begin
        if (!vown) exp_if = vdata;
        else if (!vwe) exp_dm = vdata;
      end
      check_eq("ifValid", ifValid, (cyc == vcyc && !vown));
      check_eq("dmValid", dmValid, (cyc == vcyc && vown));
      check_eq("ifData", ifData, exp_if);
      check_eq("dmRdata", dmRdata, exp_dm);
      if (!rst_now) begin
        check_eq("PCLocker", PCLocker, exp_lock);
        check_eq("IF_IDLocker", IF_IDLocker, exp_lock);
        check_eq("DECLocker", DECLocker, exp_lock);
      end
      obs_ifv = ifValid;
      obs_dmv = dmValid;
      if (rst_now) begin
        free_at = cyc + 1;
        if (vcyc > cyc) vcyc = -1;
        exp_if = '0; exp_dm = '0; last_addr = '0;
      end
      @(posedge clk); #1;
    end

    // latency-1 instance: fetch held high gives one issue every three cycles
    rst_1 = 1'b0; ifReq_1 = 1'b1; ifAddr_1 = 32'h100;
    for (int k = 0; k < 30; k++) begin
      if (k % 3 == 1) memRdata_1 = 32'hA000 + 32'(k / 3);
      else memRdata_1 = $urandom;
      @(negedge clk);
      check_eq("l1_memEn", memEn_1, (k % 3 == 0));
      if (k % 3 == 0) begin
        check_eq("l1_memAddr", memAddr_1, 32'h100);
        check_eq("l1_memWe", memWe_1, 1'b0);
      end
      check_eq("l1_ifValid", ifValid_1, (k % 3 == 2));
      if (k % 3 == 2) check_eq("l1_ifData", ifData_1, 32'hA000 + 32'(k / 3));
      check_eq("l1_dmValid", dmValid_1, 1'b0);
      check_eq("l1_dmRdata", dmRdata_1, 32'h0);
      check_eq("l1_lock", {PCLocker_1, IF_IDLocker_1, DECLocker_1}, (k % 3 == 2) ? 3'b111 : 3'b000);
      if (k == 0) check_eq("l1_wdata", memWdata_1, 32'h0);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
